// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath types and constants
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CALC_W = 8;

    // Width of a bit counter that must reach width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full adder cell
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, LSB first; SERIAL_ADDER_SAT_EN saturates on carry-out
module serial_adder
    import calc_pkg::*;
#(
    parameter int n = CALC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] in1,
    input  logic [n-1:0] in2,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] ans,
    output logic         cout
);

    localparam int             CW   = cnt_width(n);
    localparam logic [CW-1:0]  LAST = CW'(n - 1);

    state_t        state;
    state_t        state_next;
    logic [n-1:0]  a_reg;
    logic [n-1:0]  b_reg;
    logic [n-2:0]  psum;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fa_s;
    logic          fa_c;
    logic [n-1:0]  sum_full;
    logic          last_bit;

    full_adder_bit u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // psum holds the n-1 bits already produced; the current bit completes the word.
    assign sum_full = {fa_s, psum};
    assign last_bit = (cnt == LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            ans   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= in1;
                        b_reg <= in2;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg <= {1'b0, a_reg[n-1:1]};
                    b_reg <= {1'b0, b_reg[n-1:1]};
                    psum  <= sum_full[n-1:1];
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
`ifdef SERIAL_ADDER_SAT_EN
                        ans <= fa_c ? '1 : sum_full;
`else
                        ans <= sum_full;
`endif
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder for the 8-bit calculator datapath. It is the additive counterpart of the registered subtractor. It accepts two n-bit operands on a start pulse and adds them one bit per clock, LSB first, through a single full-adder cell. It returns the registered sum and carry-out with a one-cycle done pulse, trading latency for area in the calculator's arithmetic unit.

## Interface
Parameters:
- n, 8, operand and result width in bits (n ≥ 2)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled only in IDLE
- in1  input  n  augend; sampled on the accepting edge
- in2  input  n  addend; sampled on the accepting edge
- busy  output  1  high while an operation is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse; ans/cout valid while high
- ans  output  n  registered sum; holds until the next completion or reset
- cout  output  1  registered carry-out of the MSB; holds like ans

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - on start=1: latch in1/in2 into shift registers A/B, clear carry and bit counter, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - s = A[0]^B[0]^c and c' = majority(A[0],B[0],c) via the full-adder cell.
  - Shift s into the MSB of the partial-sum register; shift A and B right by one.
  - Increment the counter.
- On the RUN edge with counter = n-1: transfer the partial sum to ans and the final carry to cout, then go to DONE.
- DONE: done=1 for this single cycle; next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE: no queueing, no error. Operand changes after acceptance have no effect.
- Arithmetic: ans = (in1+in2) mod 2^n; cout = bit n of the true sum.
- rst=1 at any edge:
  - state→IDLE; ans, cout, done, busy, counter, carry and shift registers all →0.
  - An in-flight operation is discarded.
- rst has priority over start on the same edge.

## Timing
- Reset values: busy=0, done=0, ans=0, cout=0.
- start accepted at edge k. busy rises after edge k.
- Bits are processed at edges k+1 … k+n. ans/cout update and done rises at edge k+n.
- done and busy fall at edge k+n+1 (busy is high during DONE).
- Minimum spacing between accepted starts is n+2 edges. With start held high, a new operation is accepted at edge k+n+2.
- ans/cout are stable from edge k+n until the next completion; they never show partial sums.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SAT_EN defined:
  - on completion with carry-out=1, ans = all ones (2^n-1); cout still reports 1.
- SERIAL_ADDER_SAT_EN undefined:
  - ans wraps modulo 2^n.
- Latency, handshake and reset behaviour are identical in both builds.

## Structure
- Shared package calc_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default width constant CALC_W = 8;
  - counter-width derivation ($clog2(n)), used by the subtractor and this block alike.
- Sub-module: full_adder_bit. A combinational 1-bit cell with ports a, b, cin, s, cout, instantiated once.
- Top level holds:
  - the FSM;
  - the counter;
  - the A/B/partial-sum shift registers;
  - the output registers.

## Test plan
- rst=1 for 2 cycles, then rst=0, start=0 → busy=0, done=0, ans=0, cout=0, and stays so.
- in1=3, in2=5, start pulse at edge k → done=1 exactly at edge k+8 for one cycle, ans=8, cout=0, busy high k+1…k+9.
- in1=200, in2=100 → cout=1; ans=44 without SERIAL_ADDER_SAT_EN, ans=255 with it.
- in1=255, in2=1; start re-pulsed at edges k+3 and k+8; in1 changed to 0 at k+2 → first result ans=0, cout=1, done once at k+8; the extra starts are ignored.
- rst=1 at edge k+4 of an in-flight 100+27 → no done, ans=0, busy=0 next cycle. A fresh start of 100+27 → ans=127, cout=0.
- start held high continuously with in1=in2=1 → accepts at k and k+10, done at k+8 and k+18, ans=2 each time.
